// File: rtl/aes_op_controller.sv
// aes_op_controller
//   Command-level sequencer for the shared AES datapath (encryption core,
//   decryption core, key_expansion). It accepts one encrypt/decrypt command
//   at a time. It reloads the key only when the key differs from the cached
//   one. It fires a one-cycle start to the selected core and waits for the
//   rising edge of that core's done, with a timeout. It then returns the
//   result on a valid/ready response channel.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_mode              0 = encrypt, 1 = decrypt
//   cmd_key, cmd_data     AES-128 key and input block
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_error   result block; error = timeout (data forced to zero)
//   set_new_key, key_in   key-load strobe and registered key to key_expansion
//   start_enc, start_dec  one-cycle start pulses to the cores
//   enc_plain_text        operand register for the encryption core
//   dec_cipher_text       operand register for the decryption core
//   enc_cipher_text       encryption core result
//   dec_plain_text        decryption core result
//   done_enc, done_dec    core completion levels
module aes_op_controller #(
  parameter int unsigned TIMEOUT_CYCLES   = 64,
  parameter int unsigned KEY_SETUP_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_mode,
  input  logic [127:0] cmd_key,
  input  logic [127:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_error,
  output logic         set_new_key,
  output logic [127:0] key_in,
  output logic         start_enc,
  output logic         start_dec,
  output logic [127:0] enc_plain_text,
  output logic [127:0] dec_cipher_text,
  input  logic [127:0] enc_cipher_text,
  input  logic [127:0] dec_plain_text,
  input  logic         done_enc,
  input  logic         done_dec
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned KW = $clog2(KEY_SETUP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_LOAD  = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic           mode_q, mode_d;
  logic           key_valid_q, key_valid_d;
  logic [127:0]   cached_key_q, cached_key_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [KW-1:0]  key_cnt_q, key_cnt_d;
  logic           done_enc_q, done_dec_q;
  logic           rsp_valid_q, rsp_valid_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic           rsp_error_q, rsp_error_d;
  logic           set_new_key_q, set_new_key_d;
  logic [127:0]   key_in_q, key_in_d;
  logic           start_enc_q, start_enc_d;
  logic           start_dec_q, start_dec_d;
  logic [127:0]   enc_pt_q, enc_pt_d;
  logic [127:0]   dec_ct_q, dec_ct_d;
  logic           done_rise;

  // Edge detection, so that a done level left over from the previous
  // operation cannot complete the current one.
  assign done_rise = mode_q ? (done_dec & ~done_dec_q) : (done_enc & ~done_enc_q);

  // Registered outputs are computed from the transition being taken, so
  // that each strobe is visible in the first cycle of its state.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    key_valid_d   = key_valid_q;
    cached_key_d  = cached_key_q;
    tmo_cnt_d     = tmo_cnt_q;
    key_cnt_d     = key_cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    set_new_key_d = 1'b0;
    key_in_d      = key_in_q;
    start_enc_d   = 1'b0;
    start_dec_d   = 1'b0;
    enc_pt_d      = enc_pt_q;
    dec_ct_d      = dec_ct_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          mode_d = cmd_mode;
          if (cmd_mode) dec_ct_d = cmd_data;
          else          enc_pt_d = cmd_data;
          if (!key_valid_q || (cmd_key != cached_key_q)) begin
            state_d       = KEY_LOAD;
            key_in_d      = cmd_key;
            set_new_key_d = 1'b1;
            key_cnt_d     = '0;
          end else begin
            state_d     = START;
            start_enc_d = ~cmd_mode;
            start_dec_d = cmd_mode;
          end
        end
      end

      KEY_LOAD: begin
        // key_in_q already holds the latched key for this command.
        if (key_cnt_q == KW'(KEY_SETUP_CYCLES - 1)) begin
          cached_key_d = key_in_q;
          key_valid_d  = 1'b1;
          state_d      = START;
          start_enc_d  = ~mode_q;
          start_dec_d  = mode_q;
        end else begin
          key_cnt_d     = key_cnt_q + KW'(1);
          set_new_key_d = 1'b1;
        end
      end

      START: begin
        tmo_cnt_d = '0;
        state_d   = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (done_rise) begin
          rsp_data_d  = mode_q ? dec_plain_text : enc_cipher_text;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // The key state of the cores is unknown after an abort.
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          key_valid_d = 1'b0;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      key_valid_q   <= 1'b0;
      cached_key_q  <= '0;
      tmo_cnt_q     <= '0;
      key_cnt_q     <= '0;
      done_enc_q    <= 1'b0;
      done_dec_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      set_new_key_q <= 1'b0;
      key_in_q      <= '0;
      start_enc_q   <= 1'b0;
      start_dec_q   <= 1'b0;
      enc_pt_q      <= '0;
      dec_ct_q      <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      key_valid_q   <= key_valid_d;
      cached_key_q  <= cached_key_d;
      tmo_cnt_q     <= tmo_cnt_d;
      key_cnt_q     <= key_cnt_d;
      done_enc_q    <= done_enc;
      done_dec_q    <= done_dec;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      set_new_key_q <= set_new_key_d;
      key_in_q      <= key_in_d;
      start_enc_q   <= start_enc_d;
      start_dec_q   <= start_dec_d;
      enc_pt_q      <= enc_pt_d;
      dec_ct_q      <= dec_ct_d;
    end
  end

  assign cmd_ready       = (state_q == IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_error       = rsp_error_q;
  assign set_new_key     = set_new_key_q;
  assign key_in          = key_in_q;
  assign start_enc       = start_enc_q;
  assign start_dec       = start_dec_q;
  assign enc_plain_text  = enc_pt_q;
  assign dec_cipher_text = dec_ct_q;

endmodule

// File: tb/tb_aes_op_controller.sv
// Testbench for aes_op_controller. Stub cores answer known AES vectors and
// hold done as a level. A done left high from the previous operation
// drops only a few cycles after the next start. A start to one core also
// glitches the other core's done.
module tb_aes_op_controller;

  localparam int TMO = 64;
  localparam int KSC = 1;
  localparam int LAT = 5;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_mode = 1'b0;
  logic [127:0] cmd_key = '0;
  logic [127:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_error;
  logic         set_new_key;
  logic [127:0] key_in;
  logic         start_enc;
  logic         start_dec;
  logic [127:0] enc_plain_text;
  logic [127:0] dec_cipher_text;
  logic [127:0] enc_cipher_text = '0;
  logic [127:0] dec_plain_text = '0;
  logic         done_enc = 1'b0;
  logic         done_dec = 1'b0;

  aes_op_controller #(
    .TIMEOUT_CYCLES  (TMO),
    .KEY_SETUP_CYCLES(KSC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_mode       (cmd_mode),
    .cmd_key        (cmd_key),
    .cmd_data       (cmd_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_error      (rsp_error),
    .set_new_key    (set_new_key),
    .key_in         (key_in),
    .start_enc      (start_enc),
    .start_dec      (start_dec),
    .enc_plain_text (enc_plain_text),
    .dec_cipher_text(dec_cipher_text),
    .enc_cipher_text(enc_cipher_text),
    .dec_plain_text (dec_plain_text),
    .done_enc       (done_enc),
    .done_dec       (done_dec)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int snk_cnt = 0;
  int se_cnt = 0;
  int sd_cnt = 0;
  int viol = 0;
  int last_start_cyc = -1;
  int rsp_first_cyc = 0;
  bit stub_dead = 1'b0;

  typedef struct {
    logic [127:0] data;
    logic         err;
    logic         ld;
    logic         mode;
    logic [127:0] key;
    int           acc;
    int           snk0;
    int           se0;
    int           sd0;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (set_new_key) snk_cnt++;
      if (start_enc) begin se_cnt++; last_start_cyc = cyc; end
      if (start_dec) begin sd_cnt++; last_start_cyc = cyc; end
      if (start_enc && start_dec) viol++;
      if (set_new_key && (start_enc || start_dec)) viol++;
    end
  end

  function automatic logic [127:0] enc_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == P1) return C1;
    if (k == K2 && p == P2) return C2;
    return p ^ k ^ {4{32'hdeadbeef}};
  endfunction

  function automatic logic [127:0] dec_fn(input logic [127:0] k, input logic [127:0] c);
    if (k == K1 && c == C1) return P1;
    if (k == K2 && c == C2) return P2;
    return c ^ k ^ {4{32'h0badf00d}};
  endfunction

  // Stub cores
  logic [127:0] stub_key = '0;
  int  enc_cnt = 0, dec_cnt = 0;
  bit  enc_busy = 0, dec_busy = 0, enc_glitch = 0, dec_glitch = 0;
  always @(negedge clk) begin
    if (!reset_n || stub_dead) begin
      enc_busy = 0; dec_busy = 0; enc_glitch = 0; dec_glitch = 0;
    end else begin
      if (set_new_key) stub_key = key_in;
      if (enc_glitch) begin done_enc = 1'b1; enc_glitch = 0; end
      if (dec_glitch) begin done_dec = 1'b1; dec_glitch = 0; end
      if (start_enc) begin
        enc_busy = 1; enc_cnt = LAT;
        done_dec = 1'b0; dec_glitch = 1;
      end else if (enc_busy) begin
        enc_cnt--;
        if (enc_cnt == 1) done_enc = 1'b0;
        if (enc_cnt == 0) begin
          enc_cipher_text = enc_fn(stub_key, enc_plain_text);
          done_enc = 1'b1; enc_busy = 0;
        end
      end
      if (start_dec) begin
        dec_busy = 1; dec_cnt = LAT;
        done_enc = 1'b0; enc_glitch = 1;
      end else if (dec_busy) begin
        dec_cnt--;
        if (dec_cnt == 1) done_dec = 1'b0;
        if (dec_cnt == 0) begin
          dec_plain_text = dec_fn(stub_key, dec_cipher_text);
          done_dec = 1'b1; dec_busy = 0;
        end
      end
    end
  end

  task automatic issue_cmd(input logic m, input logic [127:0] k, input logic [127:0] d,
                           input logic [127:0] ed, input logic ee, input logic ld, input bit push);
    exp_t e;
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = m; cmd_key = k; cmd_data = d;
    e.data = ed; e.err = ee; e.ld = ld; e.mode = m; e.key = k;
    e.snk0 = snk_cnt; e.se0 = se_cnt; e.sd0 = sd_cnt;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept: cmd_ready=%b required 1 within 200 cycles", cmd_ready);
    end
    @(posedge clk); #1;
    e.acc = cyc;
    cmd_valid = 1'b0;
    if (push) sb.push_back(e);
  endtask

  task automatic get_rsp(input int bp);
    exp_t e;
    int n;
    logic [127:0] d0;
    bit stable;
    int exp_start;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < TMO + 100) begin @(negedge clk); n++; end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: response expected with no queued entry");
      return;
    end
    e = sb.pop_front();
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within %0d cycles", rsp_valid, TMO + 100);
      return;
    end
    rsp_first_cyc = cyc;
    if (bp > 0) begin
      d0 = rsp_data;
      stable = 1;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== d0 || cmd_ready !== 1'b0) stable = 0;
      end
      total++;
      if (!stable) begin
        bad++;
        $display("FAIL rsp_hold: valid=%b data=%h ready=%b required 1/%h/0", rsp_valid, rsp_data, cmd_ready, d0);
      end
    end
    rsp_ready = 1'b1;
    total++;
    if (rsp_data !== e.data) begin
      bad++;
      $display("FAIL rsp_data: got %h required %h", rsp_data, e.data);
    end
    total++;
    if (rsp_error !== e.err) begin
      bad++;
      $display("FAIL rsp_error: got %b required %b", rsp_error, e.err);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rsp_done: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
    total++;
    if ((snk_cnt - e.snk0) != (e.ld ? KSC : 0)) begin
      bad++;
      $display("FAIL key_load_cycles: got %0d required %0d", snk_cnt - e.snk0, e.ld ? KSC : 0);
    end
    total++;
    if ((se_cnt - e.se0) != (e.mode ? 0 : 1) || (sd_cnt - e.sd0) != (e.mode ? 1 : 0)) begin
      bad++;
      $display("FAIL start_pulses: enc=%0d dec=%0d required mode=%b one pulse", se_cnt - e.se0, sd_cnt - e.sd0, e.mode);
    end
    exp_start = e.acc + (e.ld ? KSC : 0);
    total++;
    if (last_start_cyc != exp_start) begin
      bad++;
      $display("FAIL start_latency: start cycle %0d required %0d", last_start_cyc, exp_start);
    end
    if (e.ld) begin
      total++;
      if (key_in !== e.key) begin
        bad++;
        $display("FAIL key_in: got %h required %h", key_in, e.key);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || set_new_key !== 1'b0 ||
        start_enc !== 1'b0 || start_dec !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ctrl: valid=%b err=%b snk=%b se=%b sd=%b ready=%b required 0/0/0/0/0/1",
               tag, rsp_valid, rsp_error, set_new_key, start_enc, start_dec, cmd_ready);
    end
    total++;
    if (rsp_data !== '0 || key_in !== '0 || enc_plain_text !== '0 || dec_cipher_text !== '0) begin
      bad++;
      $display("FAIL %s_data: rsp=%h key=%h pt=%h ct=%h required all zero",
               tag, rsp_data, key_in, enc_plain_text, dec_cipher_text);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
  endtask

  task automatic test_encrypt_new_key;
    issue_cmd(1'b0, K1, P1, C1, 1'b0, 1'b1, 1'b1);
    get_rsp(0);
  endtask

  task automatic test_decrypt_same_key;
    issue_cmd(1'b1, K1, C1, P1, 1'b0, 1'b0, 1'b1);
    get_rsp(0);
  endtask

  task automatic test_key_change;
    issue_cmd(1'b0, K2, P2, C2, 1'b0, 1'b1, 1'b1);
    get_rsp(0);
  endtask

  task automatic test_timeout;
    stub_dead = 1'b1;
    issue_cmd(1'b0, K2, P2, '0, 1'b1, 1'b0, 1'b1);
    get_rsp(0);
    total++;
    if (rsp_first_cyc != last_start_cyc + TMO + 1) begin
      bad++;
      $display("FAIL timeout_latency: rsp_valid cycle %0d required %0d", rsp_first_cyc, last_start_cyc + TMO + 1);
    end
    stub_dead = 1'b0;
    issue_cmd(1'b0, K2, P2, C2, 1'b0, 1'b1, 1'b1);
    get_rsp(0);
  endtask

  task automatic test_back_to_back;
    int n;
    int s0, e0, d0;
    bit ok;
    issue_cmd(1'b1, K2, C2, P2, 1'b0, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < TMO + 100) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_key = K1; cmd_data = P1;
    s0 = snk_cnt; e0 = se_cnt; d0 = sd_cnt;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== P2 || cmd_ready !== 1'b0) ok = 0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL backpressure_hold: valid=%b data=%h ready=%b required 1/%h/0", rsp_valid, rsp_data, cmd_ready, P2);
    end
    total++;
    if (snk_cnt != s0 || se_cnt != e0 || sd_cnt != d0) begin
      bad++;
      $display("FAIL backpressure_ignore: pulses snk=%0d se=%0d sd=%0d required 0", snk_cnt - s0, se_cnt - e0, sd_cnt - d0);
    end
    get_rsp(0);
    issue_cmd(1'b0, K1, P1, C1, 1'b0, 1'b1, 1'b1);
    get_rsp(3);
  endtask

  task automatic test_reset_mid_op;
    bit seen;
    stub_dead = 1'b1;
    issue_cmd(1'b0, K1, P1, '0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1;
    end
    reset_n = 1'b1;
    stub_dead = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL midreset_rsp: rsp_valid=1 seen, required 0");
    end
    issue_cmd(1'b0, K1, P1, C1, 1'b0, 1'b1, 1'b1);
    get_rsp(0);
  endtask

  initial begin
    test_reset();
    test_encrypt_new_key();
    test_decrypt_same_key();
    test_key_change();
    test_timeout();
    test_back_to_back();
    test_reset_mid_op();
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL pulse_overlap: %0d overlapping cycles, required 0", viol);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d entries, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/aes_op_controller.md
Name: aes_op_controller

Overview:
- Command-level sequencer for the shared AES datapath: the encryption core, the decryption core and the key_expansion unit.
- Accepts one encrypt or decrypt command at a time over a valid/ready interface and loads the key only when it differs from the cached key.
- Issues the single-cycle start pulse to the selected core, waits for its done with a timeout, and returns the result over a valid/ready response channel.
- Sits between the bus/host front end and the AES cores.

Parameters:
- TIMEOUT_CYCLES, 64, maximum WAIT_DONE cycles before the command is aborted with error.
- KEY_SETUP_CYCLES, 1, number of cycles set_new_key is held high per key load (>=1).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command (high only in IDLE)
- cmd_mode  input  1  0 = encrypt, 1 = decrypt
- cmd_key  input  128  AES-128 key for this command
- cmd_data  input  128  plaintext (encrypt) or ciphertext (decrypt)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_data  output  128  result block
- rsp_error  output  1  1 = timeout; rsp_data is then zero
- set_new_key  output  1  key-load strobe to key_expansion
- key_in  output  128  key to key_expansion, registered
- start_enc  output  1  one-cycle start to the encryption core
- start_dec  output  1  one-cycle start to the decryption core
- enc_plain_text  output  128  operand to the encryption core
- dec_cipher_text  output  128  operand to the decryption core
- enc_cipher_text  input  128  encryption core result
- dec_plain_text  input  128  decryption core result
- done_enc  input  1  encryption done, level
- done_dec  input  1  decryption done, level

Behaviour:
- Reset (asynchronous, reset_n low) sets these values:
  - state = IDLE; key_valid = 0; cached key = 0; timeout counter = 0.
  - All registered outputs = 0: rsp_valid, rsp_data, rsp_error, set_new_key, key_in, start_enc, start_dec, enc_plain_text, dec_cipher_text.
  - cmd_ready = 1, because it is decoded from state == IDLE.
- States: IDLE, KEY_LOAD, START, WAIT_DONE, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at an edge, latch mode, key and data.
  - Drive the operand register of the selected core only; the other operand register holds its value.
  - Next state is KEY_LOAD if key_valid = 0 or cmd_key != cached key; otherwise START.
- KEY_LOAD:
  - key_in = latched key; set_new_key = 1 for exactly KEY_SETUP_CYCLES cycles.
  - On the last cycle, cached key <= latched key, key_valid <= 1, then go to START.
- START:
  - Exactly one of start_enc/start_dec is high for one cycle, selected by mode.
  - Clear the timeout counter, then go to WAIT_DONE.
- WAIT_DONE:
  - Detect completion on the rising edge of the selected done: done & ~done_q, with done_q registered every cycle. This ignores a done level left over from the previous operation.
  - The unselected core's done is ignored.
  - On completion, rsp_data <= the selected core's result, rsp_error <= 0, go to RESP.
  - Otherwise increment the counter. On reaching TIMEOUT_CYCLES: rsp_data <= 0, rsp_error <= 1, key_valid <= 0 (forces a key reload on the next command), go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP:
  - rsp_valid = 1, with rsp_data and rsp_error held stable until rsp_ready.
  - On the rsp_valid & rsp_ready edge, go to IDLE. cmd_ready rises the following cycle; there is no same-cycle turnaround.
- Latency, with command accepted at edge T:
  - Key hit: start pulse in cycle T+1.
  - Key miss: set_new_key high for cycles T+1..T+KEY_SETUP_CYCLES; start pulse in cycle T+KEY_SETUP_CYCLES+1.
  - rsp_valid rises one cycle after the done rising edge is sampled.
- A mode change with an unchanged key does not reload the key; key_expansion serves both directions.
- cmd_valid outside IDLE is ignored. The command is held by the requester until cmd_ready.
- reset_n asserted mid-operation aborts immediately and returns to the reset values; no response is produced for the aborted command.
- start_enc and start_dec are never high in the same cycle; set_new_key is never high in the same cycle as either start.

Test Plan:
- Encrypt, new key: cmd_mode=0, key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> set_new_key high 1 cycle, then start_enc one cycle; rsp_data 3925841d02dc09fbdc118597196a0b32, rsp_error 0.
- Decrypt, same key: cmd_mode=1, data 3925841d02dc09fbdc118597196a0b32 -> no set_new_key, start_dec in cycle T+1; rsp_data 3243f6a8885a308d313198a2e0370734.
- Key change: next command with key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> set_new_key reasserted, key_in updated; rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a.
- Timeout: stub done_enc held low -> rsp_error 1 and rsp_data 0 after TIMEOUT_CYCLES; following command with the same key performs a key reload.
- Backpressure: rsp_ready held low 20 cycles -> rsp_valid and rsp_data stable, cmd_ready 0, new cmd_valid ignored; release -> IDLE, then the command is accepted.
- Reset mid-WAIT_DONE -> all outputs at reset values, key_valid 0, no rsp_valid; next command performs a key load.
